// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative data cache.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        REFILL    = 3'd3,
        ALLOCATE  = 3'd4
    } state_t;

    function automatic int tag_w(input int addr_w, input int set_bits);
        return addr_w - set_bits - 2;
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age tracking: one age per way per set, age WAYS-1 marks the victim.
module cache_lru
    import cache_pkg::*;
#(
    parameter int SET_BITS = 4,
    parameter int WAYS     = 4,
    localparam int WAY_W   = way_w(WAYS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                touch_en_i,
    input  logic [SET_BITS-1:0] set_i,
    input  logic [WAY_W-1:0]    way_i,
    output logic [WAY_W-1:0]    lru_way_o
);

    localparam int SETS = 1 << SET_BITS;

    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] touch_age_s;

    assign touch_age_s = age_q[set_i][way_i];

    // Touched way becomes youngest; only ways younger than it age by one
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else if (touch_en_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == way_i) begin
                    age_q[set_i][w] <= {WAY_W{1'b0}};
                end else if (age_q[set_i][w] < touch_age_s) begin
                    age_q[set_i][w] <= age_q[set_i][w] + WAY_W'(1);
                end
            end
        end
    end

    // Oldest way of the addressed set
    always_comb begin
        lru_way_o = {WAY_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            lru_way_o = (age_q[set_i][w] == WAY_W'(WAYS - 1)) ? WAY_W'(w) : lru_way_o;
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate data cache, one word per line.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SET_BITS = 4,
    parameter int WAYS     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              req_ready_o,
    output logic              done_o,
    output logic              hit_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int TAG_W  = tag_w(ADDR_W, SET_BITS);
    localparam int WAY_W  = way_w(WAYS);
    localparam int SETS   = 1 << SET_BITS;
    localparam int LINE_W = ADDR_W - 2;

    state_t state_q, state_d;

    logic                we_q;
    logic [LINE_W-1:0]   line_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [WAY_W-1:0]    victim_q;
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     dirty_q [SETS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [DATA_W-1:0]   data_q  [SETS][WAYS];
    logic                done_q;
    logic                hit_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic [SET_BITS-1:0] set_s;
    logic [TAG_W-1:0]    tag_s;
    logic [WAYS-1:0]     hit_vec_s;
    logic                hit_s;
    logic [WAY_W-1:0]    hit_way_s;
    logic [WAY_W-1:0]    victim_s;
    logic                victim_dirty_s;
    logic [WAY_W-1:0]    lru_way_s;
    logic                touch_en_s;
    logic [WAY_W-1:0]    touch_way_s;

    assign set_s = line_q[SET_BITS-1:0];
    assign tag_s = line_q[LINE_W-1:SET_BITS];

    // Tag compare and victim choice: lowest invalid way beats the LRU way
    always_comb begin
        hit_vec_s = {WAYS{1'b0}};
        hit_way_s = {WAY_W{1'b0}};
        victim_s  = lru_way_s;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec_s[w] = valid_q[set_s][w] && (tag_q[set_s][w] == tag_s);
            hit_way_s    = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
            victim_s     = !valid_q[set_s][w] ? WAY_W'(w) : victim_s;
        end
        hit_s          = |hit_vec_s;
        victim_dirty_s = valid_q[set_s][victim_s] && dirty_q[set_s][victim_s];
    end

    assign touch_en_s  = ((state_q == LOOKUP) && hit_s) ||
                         ((state_q == REFILL) && mem_ack_i) ||
                         (state_q == ALLOCATE);
    assign touch_way_s = (state_q == LOOKUP) ? hit_way_s : victim_q;

    cache_lru #(
        .SET_BITS (SET_BITS),
        .WAYS     (WAYS)
    ) u_lru (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .touch_en_i (touch_en_s),
        .set_i      (set_s),
        .way_i      (touch_way_s),
        .lru_way_o  (lru_way_s)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                state_d = req_i ? LOOKUP : IDLE;
            end
            LOOKUP: begin
                if (hit_s) begin
                    state_d = IDLE;
                end else if (victim_dirty_s) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = we_q ? ALLOCATE : REFILL;
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d = we_q ? ALLOCATE : REFILL;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            REFILL: begin
                state_d = mem_ack_i ? IDLE : REFILL;
            end
            ALLOCATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        req_ready_o = (state_q == IDLE);
        mem_req_o   = (state_q == WRITEBACK) || (state_q == REFILL);
        mem_we_o    = (state_q == WRITEBACK);
        done_o      = done_q;
        hit_o       = hit_q;
        rdata_o     = rdata_q;
        mem_addr_o  = mem_addr_q;
        mem_wdata_o = mem_wdata_q;
    end

    // Request latch, line status bits and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q        <= 1'b0;
            line_q      <= {LINE_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            victim_q    <= {WAY_W{1'b0}};
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            rdata_q     <= {DATA_W{1'b0}};
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= {WAYS{1'b0}};
                dirty_q[s] <= {WAYS{1'b0}};
            end
        end else begin
            done_q <= 1'b0;
            hit_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        line_q  <= addr_i[ADDR_W-1:2];
                        wdata_q <= wdata_i;
                    end
                end
                LOOKUP: begin
                    if (hit_s) begin
                        if (we_q) begin
                            dirty_q[set_s][hit_way_s] <= 1'b1;
                        end else begin
                            rdata_q <= data_q[set_s][hit_way_s];
                        end
                        done_q <= 1'b1;
                        hit_q  <= 1'b1;
                    end else begin
                        victim_q <= victim_s;
                        if (victim_dirty_s) begin
                            mem_addr_q  <= {tag_q[set_s][victim_s], set_s, 2'b00};
                            mem_wdata_q <= data_q[set_s][victim_s];
                        end else begin
                            mem_addr_q <= {line_q, 2'b00};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        dirty_q[set_s][victim_q] <= 1'b0;
                        mem_addr_q               <= {line_q, 2'b00};
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        valid_q[set_s][victim_q] <= 1'b1;
                        dirty_q[set_s][victim_q] <= 1'b0;
                        rdata_q                  <= mem_rdata_i;
                        done_q                   <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    valid_q[set_s][victim_q] <= 1'b1;
                    dirty_q[set_s][victim_q] <= 1'b1;
                    done_q                   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            case (state_q)
                LOOKUP: begin
                    if (hit_s && we_q) begin
                        data_q[set_s][hit_way_s] <= wdata_q;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        tag_q[set_s][victim_q]  <= tag_s;
                        data_q[set_s][victim_q] <= mem_rdata_i;
                    end
                end
                ALLOCATE: begin
                    tag_q[set_s][victim_q]  <= tag_s;
                    data_q[set_s][victim_q] <= wdata_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
